flash_cmd_sequencer: RTL and testbench

//  Command sequencer for the parallel flash behind the I2C front end. Takes one

---
 rtl/flash_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_flash_cmd_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_sequencer.sv
// Sequences JEDEC unlock/program/erase bus cycles and single reads to a parallel
// flash, then polls the DQ6 toggle bit to detect completion of write operations.
module flash_cmd_sequencer #(
  parameter int WE_LOW_CYC  = 2,
  parameter int WE_HIGH_CYC = 1,
  parameter int RD_CYC      = 2,
  parameter int POLL_MAX    = 50000
) (
  input  logic        SCL,
  input  logic        RESET,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdOp,
  input  logic [15:0] CmdAddr,
  input  logic [7:0]  CmdData,
  output logic [15:0] FlashAddr,
  output logic [7:0]  FlashDout,
  output logic        DoutEn,
  input  logic [7:0]  FlashDin,
  output logic        ENbar,
  output logic        WEbar,
  output logic        REbar,
  output logic [7:0]  RdData,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [7:0]    WLOW_LAST  = 8'(WE_LOW_CYC - 1);
  localparam logic [7:0]    WHIGH_LAST = 8'(WE_HIGH_CYC - 1);
  localparam logic [7:0]    RD_LAST    = 8'(RD_CYC - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_MAX - 1);

  localparam logic [1:0] OP_PROG  = 2'b00;
  localparam logic [1:0] OP_SECT  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [2:0] {IDLE, WSETUP, WLOW, WHIGH, RLOW, RHIGH, DONE} state_t;

  state_t        state, stateNext;
  logic [1:0]    opReg;
  logic [15:0]   addrReg;
  logic [7:0]    dataReg;
  logic [2:0]    step;
  logic [7:0]    cycCnt;
  logic [PW-1:0] pollCnt;
  logic          prevDq6;
  logic          timedOut;

  logic          accept, lastStep, rdEnd, dq6Match;
  logic [15:0]   tblAddr;
  logic [7:0]    tblData;
  logic          inWrite, inRead;

  assign accept   = (state == IDLE) && CmdValid;
  assign lastStep = (opReg == OP_PROG) ? (step == 3'd3) : (step == 3'd5);
  assign rdEnd    = (cycCnt == RD_LAST);
  // The first poll read has no previous sample to compare against.
  assign dq6Match = (pollCnt != '0) && (FlashDin[6] == prevDq6);

  // Unlock tables: program is 4 steps, both erases share the first 5 of 6.
  always_comb begin
    tblAddr = 16'h5555;
    tblData = 8'hAA;
    case (step)
      3'd1: begin tblAddr = 16'h2AAA; tblData = 8'h55; end
      3'd2: tblData = (opReg == OP_PROG) ? 8'hA0 : 8'h80;
      3'd3: if (opReg == OP_PROG) begin tblAddr = addrReg; tblData = dataReg; end
      3'd4: begin tblAddr = 16'h2AAA; tblData = 8'h55; end
      3'd5: if (opReg == OP_SECT) begin tblAddr = addrReg; tblData = 8'h30; end
            else tblData = 8'h10;
      default: ;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (CmdValid) stateNext = (CmdOp == OP_READ) ? RLOW : WSETUP;
      WSETUP: stateNext = WLOW;
      WLOW:   if (cycCnt == WLOW_LAST) stateNext = WHIGH;
      WHIGH:  if (cycCnt == WHIGH_LAST) stateNext = lastStep ? RLOW : WSETUP;
      RLOW:   if (rdEnd) begin
                if (opReg == OP_READ || dq6Match || pollCnt == POLL_LAST) stateNext = DONE;
                else stateNext = RHIGH;
              end
      RHIGH:  stateNext = RLOW;
      DONE:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge SCL or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge SCL or posedge RESET) begin
    if (RESET) begin
      opReg    <= '0;
      addrReg  <= '0;
      dataReg  <= '0;
      step     <= '0;
      cycCnt   <= '0;
      pollCnt  <= '0;
      prevDq6  <= 1'b0;
      timedOut <= 1'b0;
      RdData   <= '0;
    end else begin
      cycCnt <= (stateNext != state) ? 8'd0 : cycCnt + 8'd1;
      if (accept) begin
        opReg    <= CmdOp;
        addrReg  <= CmdAddr;
        dataReg  <= CmdData;
        step     <= '0;
        pollCnt  <= '0;
        timedOut <= 1'b0;
      end
      if (state == WHIGH && cycCnt == WHIGH_LAST && !lastStep) step <= step + 3'd1;
      if (state == RLOW && rdEnd) begin
        if (opReg == OP_READ) begin
          RdData <= FlashDin;
        end else begin
          prevDq6 <= FlashDin[6];
          pollCnt <= pollCnt + 1'b1;
          if (!dq6Match && pollCnt == POLL_LAST) timedOut <= 1'b1;
        end
      end
    end
  end

  // Strobes decode straight from the state register so reset raises them at once.
  assign inWrite   = (state == WSETUP) || (state == WLOW) || (state == WHIGH);
  assign inRead    = (state == RLOW) || (state == RHIGH);
  assign FlashAddr = inWrite ? tblAddr : (inRead ? addrReg : 16'h0000);
  assign FlashDout = inWrite ? tblData : 8'h00;
  assign DoutEn    = inWrite;
  assign ENbar     = !(inWrite || inRead);
  assign WEbar     = (state != WLOW);
  assign REbar     = (state != RLOW);
  assign CmdReady  = (state == IDLE);
  assign Busy      = !CmdReady;
  assign Done      = (state == DONE);
  assign Timeout   = Done && timedOut;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Directed bench for flash_cmd_sequencer with a DQ6 toggle-bit flash model;
// POLL_MAX is shortened so the timeout path is reachable.
module tb_flash_cmd_sequencer;

  logic        SCL = 1'b0;
  logic        RESET = 1'b1;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [1:0]  CmdOp = 2'b00;
  logic [15:0] CmdAddr = 16'h0000;
  logic [7:0]  CmdData = 8'h00;
  logic [15:0] FlashAddr;
  logic [7:0]  FlashDout;
  logic        DoutEn;
  logic [7:0]  FlashDin;
  logic        ENbar, WEbar, REbar;
  logic [7:0]  RdData;
  logic        Busy, Done, Timeout;

  flash_cmd_sequencer #(.WE_LOW_CYC(2), .WE_HIGH_CYC(1), .RD_CYC(2), .POLL_MAX(8)) dut (
    .SCL(SCL), .RESET(RESET), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdAddr(CmdAddr), .CmdData(CmdData),
    .FlashAddr(FlashAddr), .FlashDout(FlashDout), .DoutEn(DoutEn), .FlashDin(FlashDin),
    .ENbar(ENbar), .WEbar(WEbar), .REbar(REbar), .RdData(RdData),
    .Busy(Busy), .Done(Done), .Timeout(Timeout)
  );

  always #5 SCL = ~SCL;

  // Flash model: DQ6 toggles on each completed read until read index stableAt.
  int   rdSeen = 0;
  int   stableAt = 0;
  logic rdMode = 1'b0;
  logic [7:0] rdVal = 8'h00;
  logic dq6;
  always @(posedge REbar) rdSeen++;
  assign dq6 = (rdSeen < stableAt) ? rdSeen[0] : stableAt[0];
  assign FlashDin = rdMode ? rdVal : {1'b0, dq6, 6'b000000};

  // Bus monitor, sampled on the falling edge.
  logic [15:0] wrAddr[$];
  logic [7:0]  wrData[$];
  int          wrLen[$];
  logic [15:0] rdAddr[$];
  int weRun = 0, reRun = 0;
  logic [15:0] weA, reA;
  logic [7:0]  weD;
  int doneCnt = 0, toCnt = 0, bothCnt = 0, overlapCnt = 0;

  always @(negedge SCL) begin
    if (!WEbar && !REbar) overlapCnt++;
    if (!WEbar) begin weRun++; weA = FlashAddr; weD = FlashDout; end
    else if (weRun > 0) begin
      wrAddr.push_back(weA); wrData.push_back(weD); wrLen.push_back(weRun); weRun = 0;
    end
    if (!REbar) begin reRun++; reA = FlashAddr; end
    else if (reRun > 0) begin rdAddr.push_back(reA); reRun = 0; end
    if (Done) doneCnt++;
    if (Timeout) toCnt++;
    if (Done && Timeout) bothCnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    CmdOp = op; CmdAddr = a; CmdData = d; CmdValid = 1'b1;
    @(negedge SCL);
    CmdValid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      if (Done === 1'b1) begin ok = 1'b1; break; end
      @(negedge SCL);
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  logic [15:0] progA [4] = '{16'h5555, 16'h2AAA, 16'h5555, 16'h1234};
  logic [7:0]  progD [4] = '{8'hAA, 8'h55, 8'hA0, 8'h5A};
  logic [15:0] sectA [6] = '{16'h5555, 16'h2AAA, 16'h5555, 16'h5555, 16'h2AAA, 16'h3000};
  logic [7:0]  sectD [6] = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30};

  int wBase, rBase, dBase, tBase, bBase, badLen, badAddr;
  bit seen;

  initial begin
    // Reset state
    #1;
    check("rst_ready", {31'd0, CmdReady}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_strobes", {29'd0, ENbar, WEbar, REbar}, 32'd7);
    check("rst_douten", {31'd0, DoutEn}, 32'd0);
    check("rst_addr_dout", {8'd0, FlashAddr, FlashDout}, 32'd0);
    check("rst_rddata", {24'd0, RdData}, 32'd0);
    check("rst_done_to", {30'd0, Done, Timeout}, 32'd0);
    @(negedge SCL);
    RESET = 1'b0;
    @(negedge SCL);

    // 1: reset mid write pulse
    issue(2'b00, 16'h1234, 8'h5A);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (WEbar === 1'b0) begin seen = 1'b1; break; end
      @(negedge SCL);
    end
    check("t1_we_low_seen", {31'd0, seen}, 32'd1);
    dBase = doneCnt;
    #2 RESET = 1'b1;
    #1;
    check("t1_strobes_high", {30'd0, WEbar, ENbar}, 32'd3);
    check("t1_douten_off", {31'd0, DoutEn}, 32'd0);
    @(negedge SCL);
    RESET = 1'b0;
    repeat (20) @(negedge SCL);
    check("t1_ready_after", {31'd0, CmdReady}, 32'd1);
    check("t1_no_done", doneCnt - dBase, 32'd0);

    // 2: program with three DQ6 toggles, done on the fifth read
    rdMode = 1'b0;
    stableAt = rdSeen + 3;
    wBase = wrAddr.size(); rBase = rdAddr.size();
    dBase = doneCnt; tBase = toCnt;
    issue(2'b00, 16'h1234, 8'h5A);
    waitDone("t2_done", 200);
    check("t2_done_strobes", {28'd0, ENbar, WEbar, REbar, DoutEn}, 32'hE);
    check("t2_timeout", {31'd0, Timeout}, 32'd0);
    @(negedge SCL);
    check("t2_ready_idle", {31'd0, CmdReady}, 32'd1);
    check("t2_nwrites", wrAddr.size() - wBase, 32'd4);
    badLen = 0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_wr%0d", i), {8'd0, wrAddr[wBase+i], wrData[wBase+i]},
            {8'd0, progA[i], progD[i]});
      if (wrLen[wBase+i] != 2) badLen++;
    end
    check("t2_we_len", badLen, 32'd0);
    check("t2_nreads", rdAddr.size() - rBase, 32'd5);
    badAddr = 0;
    for (int i = rBase; i < rdAddr.size(); i++) if (rdAddr[i] != 16'h1234) badAddr++;
    check("t2_poll_addr", badAddr, 32'd0);
    check("t2_done_once", doneCnt - dBase, 32'd1);
    check("t2_no_timeout", toCnt - tBase, 32'd0);

    // 3: sector erase, one toggle then stable: three poll reads
    stableAt = rdSeen + 1;
    wBase = wrAddr.size(); rBase = rdAddr.size(); dBase = doneCnt;
    issue(2'b01, 16'h3000, 8'hFF);
    waitDone("t3_done", 200);
    check("t3_timeout", {31'd0, Timeout}, 32'd0);
    @(negedge SCL);
    check("t3_nwrites", wrAddr.size() - wBase, 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_wr%0d", i), {8'd0, wrAddr[wBase+i], wrData[wBase+i]},
            {8'd0, sectA[i], sectD[i]});
    check("t3_nreads", rdAddr.size() - rBase, 32'd3);
    badAddr = 0;
    for (int i = rBase; i < rdAddr.size(); i++) if (rdAddr[i] != 16'h3000) badAddr++;
    check("t3_poll_addr", badAddr, 32'd0);
    check("t3_done_once", doneCnt - dBase, 32'd1);

    // 4: chip erase, DQ6 never settles: timeout after 8 reads
    stableAt = 32'h7FFF_FFFF;
    wBase = wrAddr.size(); rBase = rdAddr.size();
    dBase = doneCnt; tBase = toCnt; bBase = bothCnt;
    issue(2'b10, 16'h0000, 8'h00);
    waitDone("t4_done", 300);
    check("t4_timeout_with_done", {30'd0, Done, Timeout}, 32'd3);
    @(negedge SCL);
    check("t4_nwrites", wrAddr.size() - wBase, 32'd6);
    check("t4_last_write", {8'd0, wrAddr[wBase+5], wrData[wBase+5]}, {8'd0, 16'h5555, 8'h10});
    check("t4_nreads", rdAddr.size() - rBase, 32'd8);
    check("t4_timeout_once", toCnt - tBase, 32'd1);
    check("t4_both_once", bothCnt - bBase, 32'd1);
    check("t4_done_once", doneCnt - dBase, 32'd1);

    // 5: read command cycle timing
    rdMode = 1'b1; rdVal = 8'hC3;
    wBase = wrAddr.size();
    issue(2'b11, 16'hABCD, 8'h00);
    check("t5_c1", {27'd0, REbar, WEbar, ENbar, Done, DoutEn}, 32'h08);
    check("t5_c1_addr", {16'd0, FlashAddr}, 32'hABCD);
    @(negedge SCL);
    check("t5_c2", {28'd0, REbar, WEbar, ENbar, Done}, 32'h4);
    @(negedge SCL);
    check("t5_c3", {28'd0, REbar, WEbar, ENbar, Done}, 32'hF);
    check("t5_rddata", {24'd0, RdData}, 32'hC3);
    @(negedge SCL);
    check("t5_c4_idle", {30'd0, CmdReady, Done}, 32'h2);
    check("t5_no_writes", wrAddr.size() - wBase, 32'd0);

    // 6: CmdValid held through a busy command
    rdVal = 8'h3C;
    CmdOp = 2'b11; CmdAddr = 16'h1111; CmdValid = 1'b1;
    @(negedge SCL);
    CmdAddr = 16'h2222;
    check("t6_first_addr", {16'd0, FlashAddr}, 32'h1111);
    @(negedge SCL);
    check("t6_addr_held", {16'd0, FlashAddr}, 32'h1111);
    @(negedge SCL);
    check("t6_done_busy", {30'd0, Done, CmdReady}, 32'h2);
    check("t6_rddata1", {24'd0, RdData}, 32'h3C);
    rdVal = 8'h5A;
    @(negedge SCL);
    check("t6_ready_after_done", {31'd0, CmdReady}, 32'd1);
    @(negedge SCL);
    CmdValid = 1'b0;
    check("t6_second_start", {31'd0, CmdReady, REbar}, 32'd0);
    check("t6_second_addr", {16'd0, FlashAddr}, 32'h2222);
    @(negedge SCL);
    @(negedge SCL);
    check("t6_second_done", {31'd0, Done}, 32'd1);
    check("t6_rddata2", {24'd0, RdData}, 32'h5A);
    @(negedge SCL);

    check("never_we_and_re", overlapCnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
